// File: rtl/arb_pkg.sv
// Shared definitions for the registered request arbiter: mode codes, FSM
// state encoding and the reserved "no grant" index code.
package arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // All ones of the given width; shown on the index display as "F".
  function automatic logic [31:0] no_grant_code(input int idx_w);
    return (32'd1 << idx_w) - 32'd1;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational finder: scans req descending from index 'start', wrapping
// from 0 to N-1, and returns the first set bit as one-hot and binary index.
module prio_pick
  import arb_pkg::*;
#(
  parameter int N     = 12,
  parameter int IDX_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] p;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    p      = '0;
    // Walk from lowest to highest priority so the last hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start) - k;
      if (pos < 0) pos = pos + N;
      p = IDX_W'(pos);
      if (req[p]) begin
        onehot    = '0;
        onehot[p] = 1'b1;
        idx       = p;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter: fixed-priority or round-robin selection, grant
// held until release, back-to-back re-arbitration and optional hold timeout.
module priority_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N        = 12,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt,
  output arb_state_e       state_dbg
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [IDX_W-1:0] NO_GNT   = IDX_W'(no_grant_code(IDX_W));
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(N - 1);

  arb_state_e        state, state_n;
  logic [N-1:0]      gnt_n;
  logic [IDX_W-1:0]  gnt_idx_n;
  logic              gnt_valid_n, preempt_n;
  logic [IDX_W-1:0]  last_owner, last_owner_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;

  logic [IDX_W-1:0]  start;
  logic [N-1:0]      pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              owner_req, others_req, timeout;

  // Round-robin starts just below the last owner, so the last owner is checked last.
  always_comb begin
    start = TOP_IDX;
    if (MODE == MODE_RR)
      start = (last_owner == '0) ? TOP_IDX : last_owner - IDX_W'(1);
  end

  // The current owner is always masked; the pick is only used on release or timeout.
  prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req    (req & ~gnt),
    .start  (start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign owner_req  = |(req & gnt);
  assign others_req = |(req & ~gnt);
  // '>=' keeps a contender that arrives after saturation from waiting forever.
  assign timeout    = (MAX_HOLD > 0) && owner_req && others_req &&
                      (int'(hold_cnt) >= MAX_HOLD - 1);

  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    gnt_idx_n    = gnt_idx;
    gnt_valid_n  = gnt_valid;
    preempt_n    = 1'b0;
    last_owner_n = last_owner;
    hold_cnt_n   = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_n      = ST_GRANT;
          gnt_n        = pick_onehot;
          gnt_idx_n    = pick_idx;
          gnt_valid_n  = 1'b1;
          last_owner_n = pick_idx;
          hold_cnt_n   = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || timeout) begin
          if (pick_found) begin
            gnt_n        = pick_onehot;
            gnt_idx_n    = pick_idx;
            gnt_valid_n  = 1'b1;
            last_owner_n = pick_idx;
            hold_cnt_n   = '0;
            preempt_n    = timeout;
          end else begin
            state_n     = ST_IDLE;
            gnt_n       = '0;
            gnt_idx_n   = NO_GNT;
            gnt_valid_n = 1'b0;
          end
        end else if (int'(hold_cnt) < MAX_HOLD) begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      gnt_idx    <= NO_GNT;
      gnt_valid  <= 1'b0;
      preempt    <= 1'b0;
      last_owner <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      gnt_idx    <= gnt_idx_n;
      gnt_valid  <= gnt_valid_n;
      preempt    <= preempt_n;
      last_owner <= last_owner_n;
      hold_cnt   <= hold_cnt_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench: fixed-priority instance (a) and round-robin instance with
// MAX_HOLD=4 (b), sharing clock and reset; inputs change and outputs are
// sampled on the falling edge.
module tb_priority_arbiter_rr;
  import arb_pkg::*;

  localparam int N = 12;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req_a, req_b;
  logic [N-1:0] gnt_a, gnt_b;
  logic [W-1:0] idx_a, idx_b;
  logic         valid_a, valid_b, pre_a, pre_b;
  arb_state_e   st_a, st_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  priority_arbiter_rr #(.N(N), .MODE(0), .MAX_HOLD(0)) u_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a),
    .gnt_valid(valid_a), .preempt(pre_a), .state_dbg(st_a)
  );

  priority_arbiter_rr #(.N(N), .MODE(1), .MAX_HOLD(4)) u_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b),
    .gnt_valid(valid_b), .preempt(pre_b), .state_dbg(st_b)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    req_a   = '0;
    req_b   = '0;
    repeat (2) @(negedge clk);
    total++;
    if (gnt_a !== 12'h000 || idx_a !== 4'hF || valid_a !== 1'b0 || pre_a !== 1'b0 || st_a !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_a: gnt=%h idx=%h valid=%b pre=%b st=%0d, want 000 f 0 0 0", gnt_a, idx_a, valid_a, pre_a, st_a);
    end
    total++;
    if (gnt_b !== 12'h000 || idx_b !== 4'hF || valid_b !== 1'b0 || pre_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: gnt=%h idx=%h valid=%b pre=%b, want 000 f 0 0", gnt_b, idx_b, valid_b, pre_b);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fixed();
    @(negedge clk);
    req_a = 12'h0A4;
    @(negedge clk);
    total++;
    if (gnt_a !== 12'h080 || idx_a !== 4'd7 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL fixed_first: gnt=%h idx=%0d valid=%b, want 080 7 1", gnt_a, idx_a, valid_a);
    end
    req_a = 12'h8A4;
    @(negedge clk);
    total++;
    if (gnt_a !== 12'h080 || idx_a !== 4'd7) begin
      bad++;
      $display("FAIL fixed_hold: gnt=%h idx=%0d, want 080 7", gnt_a, idx_a);
    end
    req_a = 12'h824;
    @(negedge clk);
    total++;
    if (gnt_a !== 12'h800 || idx_a !== 4'd11 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL fixed_handover: gnt=%h idx=%0d valid=%b, want 800 11 1", gnt_a, idx_a, valid_a);
    end
    req_a = 12'h000;
    @(negedge clk);
    total++;
    if (gnt_a !== 12'h000 || idx_a !== 4'hF || valid_a !== 1'b0 || st_a !== ST_IDLE) begin
      bad++;
      $display("FAIL fixed_idle: gnt=%h idx=%h valid=%b st=%0d, want 000 f 0 0", gnt_a, idx_a, valid_a, st_a);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] one;
    int e;
    req_b = 12'hFFF;
    @(negedge clk);
    for (int k = 0; k <= 12; k++) begin
      e   = (11 - k + 12) % 12;
      one = 12'h001 << e;
      total++;
      if (idx_b !== W'(e) || gnt_b !== one || pre_b !== 1'b0) begin
        bad++;
        $display("FAIL rr_order step %0d: idx=%0d gnt=%h pre=%b, want %0d %h 0", k, idx_b, gnt_b, pre_b, e, one);
      end
      req_b = 12'hFFF & ~one;
      @(negedge clk);
    end
    req_b = 12'h000;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (valid_b !== 1'b0 || idx_b !== 4'hF) begin
      bad++;
      $display("FAIL rr_idle: valid=%b idx=%h, want 0 f", valid_b, idx_b);
    end
  endtask

  task automatic test_timeout();
    req_b = 12'h028;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (idx_b !== 4'd5 || pre_b !== 1'b0) begin
        bad++;
        $display("FAIL timeout_hold5 cyc %0d: idx=%0d pre=%b, want 5 0", c, idx_b, pre_b);
      end
    end
    @(negedge clk);
    total++;
    if (idx_b !== 4'd3 || pre_b !== 1'b1 || gnt_b !== 12'h008) begin
      bad++;
      $display("FAIL timeout_to3: idx=%0d pre=%b gnt=%h, want 3 1 008", idx_b, pre_b, gnt_b);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (idx_b !== 4'd3 || pre_b !== 1'b0) begin
        bad++;
        $display("FAIL timeout_hold3 cyc %0d: idx=%0d pre=%b, want 3 0", c, idx_b, pre_b);
      end
    end
    @(negedge clk);
    total++;
    if (idx_b !== 4'd5 || pre_b !== 1'b1) begin
      bad++;
      $display("FAIL timeout_to5: idx=%0d pre=%b, want 5 1", idx_b, pre_b);
    end
    req_b = 12'h000;
    @(negedge clk);
    total++;
    if (valid_b !== 1'b0 || pre_b !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle: valid=%b pre=%b, want 0 0", valid_b, pre_b);
    end
  endtask

  task automatic test_no_contender();
    req_b = 12'h004;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (idx_b !== 4'd2 || pre_b !== 1'b0 || valid_b !== 1'b1) begin
        bad++;
        $display("FAIL solo_hold cyc %0d: idx=%0d pre=%b valid=%b, want 2 0 1", c, idx_b, pre_b, valid_b);
      end
    end
    req_b = 12'h000;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    req_a = 12'h010;
    @(negedge clk);
    total++;
    if (idx_a !== 4'd4 || gnt_a !== 12'h010) begin
      bad++;
      $display("FAIL areset_pre: idx=%0d gnt=%h, want 4 010", idx_a, gnt_a);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (gnt_a !== 12'h000 || idx_a !== 4'hF || valid_a !== 1'b0 || st_a !== ST_IDLE) begin
      bad++;
      $display("FAIL areset_now: gnt=%h idx=%h valid=%b st=%0d, want 000 f 0 0", gnt_a, idx_a, valid_a, st_a);
    end
    req_a = 12'h001;
    @(negedge clk);
    total++;
    if (valid_a !== 1'b0) begin
      bad++;
      $display("FAIL areset_held: valid=%b, want 0", valid_a);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (idx_a !== 4'd0 || gnt_a !== 12'h001 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL areset_after: idx=%0d gnt=%h valid=%b, want 0 001 1", idx_a, gnt_a, valid_a);
    end
    req_a = 12'h000;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_timeout();
    test_no_contender();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
